touch_int_init_master: RTL

- Avalon-MM initiator that drives the single-bit bidirectional touch-INT PIO slave. The slave decodes address 0 as data and address 1 as direction; it has no waitrequest and its readdata is registered with 1-cycle latency.
- Runs the touch-controller power-up sequence: drives the reset line, drives INT to the level that selects the I2C address, then releases INT.
- After release, continuously polls the INT level and emits a one-cycle interrupt pulse on each falling edge. This removes the sequencing and polling from Nios II software.

---
 rtl/touch_int_pkg.sv | 38 +++
 rtl/touch_seq_timer.sv | 35 +++
 rtl/touch_int_init_master.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/touch_int_pkg.sv
// Shared types and constants for the touch-INT init/poll master.
package touch_int_pkg;

   // Sequencer states: init sequence followed by the poll loop.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST_LOW,
      ST_WR_DATA,
      ST_WR_DIR_OUT,
      ST_ADDR_SETUP,
      ST_RST_REL,
      ST_INT_HOLD,
      ST_WR_DIR_IN,
      ST_DONE,
      ST_POLL_RD,
      ST_POLL_WAIT,
      ST_POLL_GAP
   } state_e;

   // PIO slave register map.
   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;

   // Kind of Avalon access issued in the current cycle.
   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_WRITE,
      ACC_READ
   } acc_e;

   // One single-cycle bus request as decoded from the state.
   typedef struct packed {
      acc_e       acc;
      logic [1:0] addr;
      logic       data;
   } pio_req_t;

endpackage

// File: rtl/touch_seq_timer.sv
// Loadable down-counter; zero_o flags an expired wait.
module touch_seq_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load wins over counting; the counter rests at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - ONE;
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/touch_int_init_master.sv
// Avalon-MM master running the touch-controller power-up sequence on the
// INT PIO, then polling INT and pulsing irq_pulse on confirmed falling edges.
module touch_int_init_master
   import touch_int_pkg::*;
#(
   parameter int RST_LOW_CYC    = 500000,
   parameter int ADDR_SETUP_CYC = 5000,
   parameter int INT_HOLD_CYC   = 300000,
   parameter int POLL_GAP_CYC   = 500,
   parameter int CNT_W          = 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        addr_sel,
   input  logic        poll_en,
   output logic [1:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   output logic        tp_rst_n,
   output logic        busy,
   output logic        int_level,
   output logic        irq_pulse
);

   // A wait of N cycles loads N-1 so the zero flag shows in the Nth cycle;
   // a zero length collapses to a single cycle.
   function automatic logic [CNT_W-1:0] ld_val(input int cyc);
      int v;
      v = (cyc > 0) ? cyc - 1 : 0;
      return v[CNT_W-1:0];
   endfunction

   localparam logic [CNT_W-1:0] LD_RST_LOW    = ld_val(RST_LOW_CYC);
   localparam logic [CNT_W-1:0] LD_ADDR_SETUP = ld_val(ADDR_SETUP_CYC);
   localparam logic [CNT_W-1:0] LD_INT_HOLD   = ld_val(INT_HOLD_CYC);
   localparam logic [CNT_W-1:0] LD_POLL_GAP   = ld_val(POLL_GAP_CYC);

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic             seeded_q, seeded_d;
   logic             prev_q, prev_d;
   logic             lvl_q, lvl_d;
   logic             irq_q, irq_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             start_ok;
   logic             rd_bit;
   pio_req_t         req;
   logic             unused_rd;

   assign rd_bit    = readdata[0];
   assign unused_rd = ^readdata[31:1];

   touch_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // start is honoured only while not busy; from the poll loop it re-inits.
   always_comb begin
      start_ok = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_POLL_RD, ST_POLL_WAIT, ST_POLL_GAP: start_ok = start;
         default: ;
      endcase
   end

   // Next state, addr_sel latch and timer reload on state entry.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_RST_LOW:    if (tmr_zero) state_d = ST_WR_DATA;
         ST_WR_DATA:    state_d = ST_WR_DIR_OUT;
         ST_WR_DIR_OUT: state_d = ST_ADDR_SETUP;
         ST_ADDR_SETUP: if (tmr_zero) state_d = ST_RST_REL;
         ST_RST_REL:    state_d = ST_INT_HOLD;
         ST_INT_HOLD:   if (tmr_zero) state_d = ST_WR_DIR_IN;
         ST_WR_DIR_IN:  state_d = ST_DONE;
         ST_DONE:       if (poll_en) state_d = ST_POLL_RD;
         ST_POLL_RD:    state_d = ST_POLL_WAIT;
         ST_POLL_WAIT:  state_d = ST_POLL_GAP;
         ST_POLL_GAP:   if (tmr_zero) state_d = ST_DONE;
         default:       state_d = ST_IDLE;
      endcase
      if (start_ok) begin
         state_d = ST_RST_LOW;
         sel_d   = addr_sel;
      end
      if (state_d != state_q) begin
         case (state_d)
            ST_RST_LOW:    begin tmr_load = 1'b1; tmr_val = LD_RST_LOW;    end
            ST_ADDR_SETUP: begin tmr_load = 1'b1; tmr_val = LD_ADDR_SETUP; end
            ST_INT_HOLD:   begin tmr_load = 1'b1; tmr_val = LD_INT_HOLD;   end
            ST_POLL_GAP:   begin tmr_load = 1'b1; tmr_val = LD_POLL_GAP;   end
            default: ;
         endcase
      end
   end

   // Glitch filter: a level is accepted only after two equal samples; the
   // first sample after init just seeds the history.
   always_comb begin
      seeded_d = seeded_q;
      prev_d   = prev_q;
      lvl_d    = lvl_q;
      irq_d    = 1'b0;
      if (state_q == ST_WR_DIR_IN) begin
         seeded_d = 1'b0;
      end else if (state_q == ST_POLL_WAIT) begin
         seeded_d = 1'b1;
         prev_d   = rd_bit;
         if (seeded_q && (rd_bit == prev_q) && (rd_bit != lvl_q)) begin
            lvl_d = rd_bit;
            irq_d = ~rd_bit;
         end
      end
   end

   // State and filter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         seeded_q <= 1'b0;
         prev_q   <= 1'b1;
         lvl_q    <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         seeded_q <= seeded_d;
         prev_q   <= prev_d;
         lvl_q    <= lvl_d;
         irq_q    <= irq_d;
      end
   end

   // Moore bus decode: each access state is exactly one bus cycle.
   always_comb begin
      req = '{acc: ACC_NONE, addr: PIO_ADDR_DATA, data: 1'b0};
      case (state_q)
         ST_WR_DATA:    req = '{acc: ACC_WRITE, addr: PIO_ADDR_DATA, data: sel_q};
         ST_WR_DIR_OUT: req = '{acc: ACC_WRITE, addr: PIO_ADDR_DIR,  data: 1'b1};
         ST_WR_DIR_IN:  req = '{acc: ACC_WRITE, addr: PIO_ADDR_DIR,  data: 1'b0};
         ST_POLL_RD:    req = '{acc: ACC_READ,  addr: PIO_ADDR_DATA, data: 1'b0};
         default: ;
      endcase
      chipselect = (req.acc != ACC_NONE);
      write_n    = (req.acc != ACC_WRITE);
      address    = req.addr;
      writedata  = {31'b0, (req.acc == ACC_WRITE) & req.data};
   end

   // Reset line and busy from the state: reset released from RST_REL on.
   always_comb begin
      tp_rst_n = 1'b0;
      busy     = 1'b0;
      case (state_q)
         ST_RST_LOW, ST_WR_DATA, ST_WR_DIR_OUT, ST_ADDR_SETUP: busy = 1'b1;
         ST_RST_REL, ST_INT_HOLD, ST_WR_DIR_IN: begin
            busy     = 1'b1;
            tp_rst_n = 1'b1;
         end
         ST_DONE, ST_POLL_RD, ST_POLL_WAIT, ST_POLL_GAP: tp_rst_n = 1'b1;
         default: ;
      endcase
   end

   assign int_level = lvl_q;
   assign irq_pulse = irq_q;

endmodule
